// File: rtl/vfx_pkg.sv
// Shared definitions for the video-effects pipeline.
//  PIX_W       : width of an assembled {R,G,B} RGB444 pixel
//  IMG_W_BITS  : width of column coordinates / image_width
//  IMG_H_BITS  : width of row coordinates / image_height
//  pixel_t     : one assembled pixel
//  cap_state_t : capture front-end frame state
package vfx_pkg;

  localparam int PIX_W      = 12;
  localparam int IMG_W_BITS = 10;
  localparam int IMG_H_BITS = 9;

  typedef logic [PIX_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    VBLANK  = 2'd1,
    ACTIVE  = 2'd2
  } cap_state_t;

  // Column increment that sticks at the last legal column.
  function automatic logic [IMG_W_BITS-1:0] sat_inc_col(
    input logic [IMG_W_BITS-1:0] v,
    input logic [IMG_W_BITS-1:0] lim
  );
    return (v >= lim) ? lim : v + 10'd1;
  endfunction

  // Row increment that sticks at the last legal row.
  function automatic logic [IMG_H_BITS-1:0] sat_inc_row(
    input logic [IMG_H_BITS-1:0] v,
    input logic [IMG_H_BITS-1:0] lim
  );
    return (v >= lim) ? lim : v + 9'd1;
  endfunction

endpackage

// File: rtl/rgb444_byte_packer.sv
// Pairs camera bytes into RGB444 pixels.
//  clk, rst_n   : pixel clock, async active-low reset
//  clear        : forces byte phase back to 0 (line end / outside active frame)
//  byte_en      : cam_data carries a valid line byte this cycle
//  cam_data     : camera byte bus
//  phase        : 1 when a first (R) byte is waiting for its partner
//  pixel        : {R,G,B} formed from the held R nibble and the current byte
//  pixel_valid  : pixel is complete this cycle (second byte of a pair)
module rgb444_byte_packer
  import vfx_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       byte_en,
  input  logic [7:0] cam_data,
  output logic       phase,
  output pixel_t     pixel,
  output logic       pixel_valid
);

  logic       phase_r;
  logic [3:0] hi_r;

  // Byte phase toggle and capture of the red nibble on the first byte of a pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_r <= 1'b0;
      hi_r    <= 4'd0;
    end else if (clear) begin
      phase_r <= 1'b0;
    end else if (byte_en) begin
      phase_r <= ~phase_r;
      if (!phase_r) begin
        hi_r <= cam_data[3:0];
      end
    end
  end

  assign phase       = phase_r;
  assign pixel       = {hi_r, cam_data[7:4], cam_data[3:0]};
  assign pixel_valid = byte_en & phase_r;

endmodule

// File: rtl/camera_pixel_capture.sv
// OV7670 capture front end: frames the RGB444 byte stream with vsync/href,
// crops each frame to image_width x image_height and emits one registered
// pixel strobe per assembled pixel.
//  clk, rst_n            : pixel clock, async active-low reset
//  enable                : capture enable, sampled at vsync fall only
//  vsync, href, cam_data : camera interface
//  image_width/height    : crop size, latched at frame start
//  ready_out/data_out    : pixel strobe and pixel (data held between strobes)
//  x_out, y_out          : coordinates of data_out
//  frame_done            : one-cycle pulse when a captured frame ends
//  line_err              : sticky odd-byte-count flag, cleared at frame start
module camera_pixel_capture
  import vfx_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int MAX_W  = 640,
  parameter int MAX_H  = 480
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  vsync,
  input  logic                  href,
  input  logic [7:0]            cam_data,
  input  logic [IMG_W_BITS-1:0] image_width,
  input  logic [IMG_H_BITS-1:0] image_height,
  output logic                  ready_out,
  output logic [DATA_W-1:0]     data_out,
  output logic [IMG_W_BITS-1:0] x_out,
  output logic [IMG_H_BITS-1:0] y_out,
  output logic                  frame_done,
  output logic                  line_err
);

  localparam logic [IMG_W_BITS-1:0] COL_LAST = IMG_W_BITS'(MAX_W - 1);
  localparam logic [IMG_H_BITS-1:0] ROW_LAST = IMG_H_BITS'(MAX_H - 1);

  cap_state_t            state_r, state_nxt_s;
  logic                  href_d_r;
  logic [IMG_W_BITS-1:0] col_r, width_l_r;
  logic [IMG_H_BITS-1:0] row_r, height_l_r;
  logic                  line_has_pix_r;
  logic                  line_err_r, frame_done_r, ready_r;
  logic [DATA_W-1:0]     data_r;
  logic [IMG_W_BITS-1:0] x_r;
  logic [IMG_H_BITS-1:0] y_r;

  logic   active_s, frame_start_s, frame_end_s, line_end_s;
  logic   byte_en_s, clear_s, pack_phase_s, pix_valid_s, in_crop_s;
  pixel_t pix_s;

  assign active_s      = (state_r == ACTIVE);
  assign frame_start_s = (state_r == VBLANK) && !vsync && enable;
  assign frame_end_s   = active_s && vsync;
  // href falling inside the frame closes a line; a simultaneous vsync rise wins.
  assign line_end_s    = active_s && !vsync && href_d_r && !href;
  assign byte_en_s     = active_s && !vsync && href;
  // Outside the active frame the packer is held at phase 0, which also
  // discards a half pixel left when vsync rises mid-line.
  assign clear_s       = !active_s || vsync || line_end_s;
  assign in_crop_s     = (col_r < width_l_r) && (row_r < height_l_r);

  rgb444_byte_packer u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear_s),
    .byte_en     (byte_en_s),
    .cam_data    (cam_data),
    .phase       (pack_phase_s),
    .pixel       (pix_s),
    .pixel_valid (pix_valid_s)
  );

  // Frame state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= WAIT_VS;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; reset lands in WAIT_VS so a full vsync high period is
  // required before the first frame is captured.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      WAIT_VS: begin
        if (vsync) state_nxt_s = VBLANK;
        else       state_nxt_s = WAIT_VS;
      end
      VBLANK: begin
        if (!vsync) state_nxt_s = enable ? ACTIVE : WAIT_VS;
        else        state_nxt_s = VBLANK;
      end
      ACTIVE: begin
        if (vsync) state_nxt_s = VBLANK;
        else       state_nxt_s = ACTIVE;
      end
      default: state_nxt_s = WAIT_VS;
    endcase
  end

  // Delayed href for line-end edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      href_d_r <= 1'b0;
    end else begin
      href_d_r <= href;
    end
  end

  // Column/row counters, latched crop size and sticky line error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_r          <= '0;
      row_r          <= '0;
      width_l_r      <= '0;
      height_l_r     <= '0;
      line_has_pix_r <= 1'b0;
      line_err_r     <= 1'b0;
    end else if (frame_start_s) begin
      col_r          <= '0;
      row_r          <= '0;
      width_l_r      <= image_width;
      height_l_r     <= image_height;
      line_has_pix_r <= 1'b0;
      line_err_r     <= 1'b0;
    end else if (line_end_s) begin
      col_r          <= '0;
      line_has_pix_r <= 1'b0;
      if (line_has_pix_r) row_r <= sat_inc_row(row_r, ROW_LAST);
      if (pack_phase_s)   line_err_r <= 1'b1;
    end else if (pix_valid_s) begin
      col_r          <= sat_inc_col(col_r, COL_LAST);
      line_has_pix_r <= 1'b1;
    end
  end

  // Registered pixel outputs; data/x/y hold between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_r      <= 1'b0;
      data_r       <= '0;
      x_r          <= '0;
      y_r          <= '0;
      frame_done_r <= 1'b0;
    end else begin
      ready_r      <= 1'b0;
      frame_done_r <= frame_end_s;
      if (pix_valid_s && in_crop_s) begin
        ready_r <= 1'b1;
        data_r  <= DATA_W'(pix_s);
        x_r     <= col_r;
        y_r     <= row_r;
      end
    end
  end

  assign ready_out  = ready_r;
  assign data_out   = data_r;
  assign x_out      = x_r;
  assign y_out      = y_r;
  assign frame_done = frame_done_r;
  assign line_err   = line_err_r;

endmodule

// File: tb/tb_camera_pixel_capture.sv
// Self-checking bench for camera_pixel_capture: a frame-level reference model
// predicts every pixel strobe from the bytes driven, table-driven frames cover
// cropping / odd lines / disabled frames, and hand sequences cover reset and
// exact strobe timing.
module tb_camera_pixel_capture;

  logic       clk = 1'b0;
  logic       rst_n, enable, vsync, href;
  logic [7:0] cam_data;
  logic [9:0] image_width;
  logic [8:0] image_height;
  logic       ready_out, frame_done, line_err;
  logic [11:0] data_out;
  logic [9:0] x_out;
  logic [8:0] y_out;

  camera_pixel_capture dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .vsync(vsync), .href(href),
    .cam_data(cam_data), .image_width(image_width), .image_height(image_height),
    .ready_out(ready_out), .data_out(data_out), .x_out(x_out), .y_out(y_out),
    .frame_done(frame_done), .line_err(line_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] d;
    logic [9:0]  x;
    logic [8:0]  y;
  } exp_t;

  typedef struct {
    bit en; int w; int h; int lines; int len; int odd_line; int exp_pix; bit exp_err;
  } frame_vec_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vectors = 0, miscompares = 0;
  int   fd_cnt = 0, strobe_cnt = 0;

  // reference model state
  bit   m_en = 1'b0, m_err = 1'b0;
  int   m_row = 0, m_w = 0, m_h = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Output monitor: every strobe must match the next predicted pixel.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_done) fd_cnt++;
      if (ready_out) begin
        strobe_cnt++;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_strobe: got x=%0d y=%0d data=%h, expected no strobe at %0t", x_out, y_out, data_out, $time);
        end else begin
          mon_e = exp_q.pop_front();
          if (data_out !== mon_e.d || x_out !== mon_e.x || y_out !== mon_e.y) begin
            miscompares++;
            $display("FAIL pixel: got x=%0d y=%0d data=%h, expected x=%0d y=%0d data=%h at %0t",
                     x_out, y_out, data_out, mon_e.x, mon_e.y, mon_e.d, $time);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ends the current frame with a vsync high period and starts the next one.
  task automatic frame_boundary(input bit en, input int w, input int h);
    int fd0;
    fd0 = fd_cnt;
    vsync = 1'b1; href = 1'b0;
    repeat (4) tick();
    check("frame_done_count", fd_cnt - fd0, m_en ? 1 : 0);
    check("pending_pixels", exp_q.size(), 0);
    exp_q.delete();
    image_width = 10'(w); image_height = 9'(h); enable = en;
    vsync = 1'b0;
    tick();
    // changes after the vsync fall must not affect this frame
    enable = 1'b1;
    image_width = 10'($urandom_range(1, 640));
    image_height = 9'($urandom_range(1, 480));
    repeat (2) tick();
    m_en = en;
    if (en) begin
      m_row = 0; m_err = 1'b0; m_w = w; m_h = h;
    end
  endtask

  // Drives one href line of len random bytes and predicts its pixels.
  task automatic send_line(input int len);
    logic [7:0] b[32];
    int np;
    np = len / 2;
    for (int i = 0; i < len; i++) b[i] = 8'($urandom);
    if (m_en) begin
      for (int k = 0; k < np; k++)
        if (k < m_w && m_row < m_h)
          exp_q.push_back('{d: {b[2*k][3:0], b[2*k+1]}, x: 10'(k), y: 9'(m_row)});
      if (np > 0) m_row++;
      if (len % 2 == 1) m_err = 1'b1;
    end
    if (len > 0) begin
      href = 1'b1;
      for (int i = 0; i < len; i++) begin
        cam_data = b[i];
        tick();
      end
      href = 1'b0;
    end
    cam_data = 8'($urandom);
    repeat (3) tick();
    check("line_err", int'(line_err), int'(m_err));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready_out"}, int'(ready_out), 0);
    check({tag, "_data_out"}, int'(data_out), 0);
    check({tag, "_x_out"}, int'(x_out), 0);
    check({tag, "_y_out"}, int'(y_out), 0);
    check({tag, "_frame_done"}, int'(frame_done), 0);
    check({tag, "_line_err"}, int'(line_err), 0);
  endtask

  frame_vec_t tbl[6];

  initial begin
    int s0;
    tbl[0] = '{en:1'b1, w:4, h:2, lines:2, len:8,  odd_line:-1, exp_pix:8,  exp_err:1'b0};
    tbl[1] = '{en:1'b1, w:4, h:2, lines:3, len:12, odd_line:-1, exp_pix:8,  exp_err:1'b0};
    tbl[2] = '{en:1'b1, w:8, h:4, lines:3, len:8,  odd_line:1,  exp_pix:11, exp_err:1'b1};
    tbl[3] = '{en:1'b0, w:4, h:2, lines:2, len:8,  odd_line:-1, exp_pix:0,  exp_err:1'b1};
    tbl[4] = '{en:1'b1, w:3, h:1, lines:3, len:10, odd_line:-1, exp_pix:3,  exp_err:1'b0};
    tbl[5] = '{en:1'b1, w:1, h:3, lines:3, len:2,  odd_line:0,  exp_pix:2,  exp_err:1'b1};

    // reset, camera already mid-frame
    rst_n = 1'b0; enable = 1'b1; vsync = 1'b0; href = 1'b0; cam_data = 8'h00;
    image_width = 10'd4; image_height = 9'd2;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    // released mid-frame: nothing may be captured (m_en stays 0)
    send_line(6);
    send_line(5);
    send_line(8);

    // exact pairing and strobe timing: 0x0A, 0x5C -> A5C
    frame_boundary(1'b1, 4, 2);
    exp_q.push_back('{d: 12'hA5C, x: 10'd0, y: 9'd0});
    href = 1'b1; cam_data = 8'h0A; tick();
    cam_data = 8'h5C; tick();
    check("pair_ready_high", int'(ready_out), 1);
    check("pair_data", int'(data_out), 12'hA5C);
    href = 1'b0; cam_data = 8'hFF; tick();
    check("pair_ready_one_cycle", int'(ready_out), 0);
    check("pair_data_hold", int'(data_out), 12'hA5C);
    repeat (2) tick();
    m_row = 1;

    // reset in the middle of a line: abort, no frame_done afterwards
    href = 1'b1; cam_data = 8'h33; tick();
    rst_n = 1'b0; #1;
    check_reset_outputs("midline_reset");
    exp_q.delete(); m_en = 1'b0; m_err = 1'b0;
    tick(); href = 1'b0; tick();
    rst_n = 1'b1;
    send_line(4);

    // table-driven frames
    for (int t = 0; t < 6; t++) begin
      frame_boundary(tbl[t].en, tbl[t].w, tbl[t].h);
      s0 = strobe_cnt;
      for (int l = 0; l < tbl[t].lines; l++)
        send_line(l == tbl[t].odd_line ? tbl[t].len - 1 : tbl[t].len);
      check($sformatf("table%0d_strobes", t), strobe_cnt - s0, tbl[t].exp_pix);
      check($sformatf("table%0d_line_err", t), int'(line_err), int'(tbl[t].exp_err));
    end

    // randomized frames against the model
    for (int f = 0; f < 8; f++) begin
      frame_boundary(($urandom_range(0, 4) != 0), $urandom_range(1, 8), $urandom_range(1, 4));
      for (int l = $urandom_range(1, 5); l > 0; l--)
        send_line($urandom_range(0, 13));
    end
    frame_boundary(1'b0, 4, 2);
    send_line(6);
    frame_boundary(1'b0, 4, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #2000000;
    $display("FAIL timeout: got no end of test, expected completion before 2000000");
    $fatal(1, "timeout");
  end

endmodule
